// File: rtl/kfps2kb_receive_frame_if.sv
// Signal bundle between the PS/2 frame receiver, the PS/2 lines, the host sender and the consumer.
// The receiver uses the slave view; whatever drives the lines and the handshake uses the master view.
interface kfps2kb_receive_frame_if;
  logic       peripheral_clock;
  logic       device_clock;
  logic       device_data;
  logic       sending_data_flag;
  logic       read_ack;
  logic       device_clock_out;
  logic       receiving_flag;
  logic [7:0] recv_data;
  logic       data_full;
  logic       recv_valid;
  logic       parity_error;
  logic       framing_error;
  logic       timeout_error;

  modport master (
    output peripheral_clock, device_clock, device_data, sending_data_flag, read_ack,
    input  device_clock_out, receiving_flag, recv_data, data_full,
           recv_valid, parity_error, framing_error, timeout_error
  );

  modport slave (
    input  peripheral_clock, device_clock, device_data, sending_data_flag, read_ack,
    output device_clock_out, receiving_flag, recv_data, data_full,
           recv_valid, parity_error, framing_error, timeout_error
  );
endinterface

// File: rtl/kfps2kb_receive_frame.sv
// PS/2 device-to-host frame receiver: filters the PS/2 clock, shifts in 11-bit frames, holds one
// byte for the consumer and inhibits the device while that byte is unread.
module kfps2kb_receive_frame #(
  parameter logic [7:0]  clock_filter_length = 8'd8,
  parameter logic [15:0] receive_timeout     = 16'd2000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  kfps2kb_receive_frame_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    CHECK
  } state_e;

  state_e      r_state;
  state_e      w_state_next;

  logic [1:0]  r_dclk_sync;
  logic [1:0]  r_ddat_sync;
  logic [1:0]  r_pclk_sync;
  logic        r_pclk_prev;
  logic        r_filt_clk;
  logic        r_filt_prev;
  logic [7:0]  r_filt_cnt;
  logic [9:0]  r_shift;
  logic [3:0]  r_bit_count;
  logic [15:0] r_to_cnt;
  logic [7:0]  r_recv_data;
  logic        r_data_full;
  logic        r_dclk_out;
  logic        r_recv_valid;
  logic        r_parity_error;
  logic        r_framing_error;
  logic        r_timeout_error;
  logic        r_ack_prev;

  logic        w_fall;
  logic        w_data_bit;
  logic        w_pclk_rise;
  logic        w_gate;
  logic        w_ack_rise;
  logic        w_start;
  logic        w_shift_en;
  logic        w_to_clear;
  logic        w_to_inc;
  logic        w_load;
  logic        w_parity_err;
  logic        w_framing_err;
  logic        w_timeout_err;
  logic        w_data_full_next;
  logic [15:0] w_to_cnt_inc;

  // Synchronisers start at the idle bus levels so reset never looks like a clock fall.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dclk_sync <= 2'b11;
      r_ddat_sync <= 2'b11;
      r_pclk_sync <= 2'b00;
      r_pclk_prev <= 1'b0;
    end else begin
      r_dclk_sync <= {r_dclk_sync[0], bus.device_clock};
      r_ddat_sync <= {r_ddat_sync[0], bus.device_data};
      r_pclk_sync <= {r_pclk_sync[0], bus.peripheral_clock};
      r_pclk_prev <= r_pclk_sync[1];
    end
  end

  assign w_pclk_rise = r_pclk_sync[1] & ~r_pclk_prev;
  assign w_data_bit  = r_ddat_sync[1];

  // The filtered clock flips only after clock_filter_length consecutive disagreeing samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_filt_clk  <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_filt_prev <= r_filt_clk;
      if (r_dclk_sync[1] == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == clock_filter_length - 8'd1) begin
        r_filt_clk <= r_dclk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 8'd1;
      end
    end
  end

  assign w_fall       = r_filt_prev & ~r_filt_clk;
  assign w_gate       = r_data_full | bus.sending_data_flag;
  assign w_ack_rise   = bus.read_ack & ~r_ack_prev;
  assign w_to_cnt_inc = r_to_cnt + 16'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_shift_en    = 1'b0;
    w_to_clear    = 1'b0;
    w_to_inc      = 1'b0;
    w_load        = 1'b0;
    w_parity_err  = 1'b0;
    w_framing_err = 1'b0;
    w_timeout_err = 1'b0;
    if (w_gate) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_fall && !w_data_bit) begin
            w_state_next = RECEIVE;
            w_start      = 1'b1;
            w_to_clear   = 1'b1;
          end
        end
        RECEIVE: begin
          if (w_fall) begin
            w_shift_en = 1'b1;
            w_to_clear = 1'b1;
            if (r_bit_count == 4'd9) begin
              w_state_next = CHECK;
            end
          end else if (w_pclk_rise) begin
            if (w_to_cnt_inc == receive_timeout) begin
              w_timeout_err = 1'b1;
              w_state_next  = IDLE;
            end else begin
              w_to_inc = 1'b1;
            end
          end
        end
        CHECK: begin
          w_state_next = IDLE;
          if (!r_shift[9]) begin
            w_framing_err = 1'b1;
          end else if ((^r_shift[8:0]) == 1'b0) begin
            w_parity_err = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Bits enter at the MSB, so after the stop bit: [7:0] data, [8] parity, [9] stop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_bit_count <= '0;
      r_to_cnt    <= '0;
    end else begin
      if (w_start) begin
        r_shift     <= '0;
        r_bit_count <= '0;
      end else if (w_shift_en) begin
        r_shift     <= {w_data_bit, r_shift[9:1]};
        r_bit_count <= r_bit_count + 4'd1;
      end
      if (w_to_clear) begin
        r_to_cnt <= '0;
      end else if (w_to_inc) begin
        r_to_cnt <= w_to_cnt_inc;
      end
    end
  end

  // A load in the same cycle as an acknowledge edge wins, keeping the new byte marked unread.
  assign w_data_full_next = w_load ? 1'b1 : (w_ack_rise ? 1'b0 : r_data_full);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_recv_data     <= 8'h00;
      r_data_full     <= 1'b0;
      r_dclk_out      <= 1'b1;
      r_recv_valid    <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
      r_timeout_error <= 1'b0;
      r_ack_prev      <= 1'b0;
    end else begin
      r_ack_prev      <= bus.read_ack;
      r_data_full     <= w_data_full_next;
      r_dclk_out      <= ~w_data_full_next;
      r_recv_valid    <= w_load;
      r_parity_error  <= w_parity_err;
      r_framing_error <= w_framing_err;
      r_timeout_error <= w_timeout_err;
      if (w_load) begin
        r_recv_data <= r_shift[7:0];
      end
    end
  end

  assign bus.device_clock_out = r_dclk_out;
  assign bus.receiving_flag   = (r_state == RECEIVE) || (r_state == CHECK);
  assign bus.recv_data        = r_recv_data;
  assign bus.data_full        = r_data_full;
  assign bus.recv_valid       = r_recv_valid;
  assign bus.parity_error     = r_parity_error;
  assign bus.framing_error    = r_framing_error;
  assign bus.timeout_error    = r_timeout_error;

endmodule
